// File: rtl/rv32i_wb_trace.sv
// rtl/rv32i_wb_trace.sv - commit-trace capture FIFO and framed byte serializer for sam_rv32i
//
// Detects each retirement as a change in npc_i, buffers {npc, wb} records in a
// circular FIFO and streams them as 9-byte frames: SYNC, NPC[31:0] MSB first,
// WB[31:0] MSB first.
//
// Ports:
//   clk      core clock, all state updates on the rising edge
//   RN       synchronous active-low reset
//   npc_i    core NPC output
//   wb_i     core WB_OUT output
//   en_i     capture enable
//   tx_data  stream byte (registered)
//   tx_valid stream byte valid (registered)
//   tx_ready sink accepts byte
//   count    records currently held in the FIFO
//   full     count == DEPTH
//   empty    count == 0
//   ovf_cnt  records dropped because the FIFO was full, saturating

module rv32i_wb_trace #(
  parameter int          DEPTH = 16,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic                     clk,
  input  logic                     RN,
  input  logic [31:0]              npc_i,
  input  logic [31:0]              wb_i,
  input  logic                     en_i,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [3:0]    IDX_LAST = 4'd8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_next;
  logic [31:0]   prev_npc;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [63:0]   sreg;
  logic [3:0]    idx;
  logic          push_req, push_ok, pop;

  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign tx_valid = (state == SEND);

  assign push_req = en_i && (npc_i != prev_npc);
  // A pop on the same edge frees the slot being written, so a full FIFO
  // can still accept the record.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (tx_ready && idx == IDX_LAST) begin
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Record storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {npc_i, wb_i};
  end

  always_ff @(posedge clk) begin
    if (!RN) begin
      prev_npc <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_cnt  <= '0;
    end else begin
      prev_npc <= npc_i;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push_req && !push_ok && ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  // tx_data is loaded with SYNC on a pop, then each accepted byte shifts the
  // next record byte out of the top of sreg.
  always_ff @(posedge clk) begin
    if (!RN) begin
      state   <= IDLE;
      tx_data <= '0;
      sreg    <= '0;
      idx     <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        sreg    <= mem[rd_ptr];
        tx_data <= SYNC;
        idx     <= '0;
      end else if (state == SEND && tx_ready && idx != IDX_LAST) begin
        tx_data <= sreg[63:56];
        sreg    <= {sreg[55:0], 8'h00};
        idx     <= idx + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_wb_trace.sv
// tb/tb_rv32i_wb_trace.sv - scoreboard bench for rv32i_wb_trace

module tb_rv32i_wb_trace;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic                   clk = 1'b0;
  logic                   RN;
  logic [31:0]            npc_i, wb_i;
  logic                   en_i;
  logic [7:0]             tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [$clog2(DEPTH):0] count;
  logic                   full, empty;
  logic [15:0]            ovf_cnt;

  rv32i_wb_trace #(.DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clk(clk), .RN(RN), .npc_i(npc_i), .wb_i(wb_i), .en_i(en_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .count(count), .full(full), .empty(empty), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // {last_byte_of_frame, byte}
  logic [8:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [31:0] n, input logic [31:0] w);
    exp_q.push_back({1'b0, SYNC});
    for (int i = 3; i >= 0; i--) exp_q.push_back({1'b0, n[i*8 +: 8]});
    for (int i = 3; i >= 0; i--) exp_q.push_back({(i == 0), w[i*8 +: 8]});
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
    check(tag, exp_q.size(), 0);
    step();
    step();
  endtask

  // Byte monitor, sampled mid-cycle on the falling edge.
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = '0;
  logic       gap_pend   = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!RN) begin
      stall_pend = 1'b0;
      gap_pend   = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, stall_data);
      end
      if (gap_pend && exp_q.size() != 0) check("no_gap", tx_valid, 1);
      stall_pend = 1'b0;
      gap_pend   = 1'b0;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_data, e[7:0]);
          gap_pend = e[8];
        end
      end else if (tx_valid && !tx_ready) begin
        stall_pend = 1'b1;
        stall_data = tx_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         bad;
    logic [3:0] pat;
    RN = 1'b0; en_i = 1'b0; npc_i = '0; wb_i = '0; tx_ready = 1'b0;
    step();
    step();
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf_cnt, 0);
    RN = 1'b1;
    step();

    // Single retire
    tx_ready = 1'b1;
    en_i = 1'b1; npc_i = 32'h4; wb_i = 32'h11;
    push_frame(32'h4, 32'h11);
    step();
    check("t1_count", count, 1);
    check("t1_empty", empty, 0);
    check("t1_valid_early", tx_valid, 0);
    step();
    check("t1_valid", tx_valid, 1);
    check("t1_sync", tx_data, SYNC);
    repeat (9) step();
    check("t1_done", exp_q.size(), 0);
    check("t1_idle", tx_valid, 0);
    check("t1_empty_end", empty, 1);

    // No change / disabled capture
    en_i = 1'b0; npc_i = 32'h8;
    step();
    en_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (count != 0 || tx_valid) bad++;
    end
    en_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      npc_i = 32'h40 + c * 4;
      step();
      if (count != 0 || tx_valid) bad++;
    end
    check("no_capture", bad, 0);

    // Backpressure
    npc_i = 32'h4;
    step();
    en_i = 1'b1;
    npc_i = 32'h8; wb_i = 32'hDEAD_0022;
    push_frame(npc_i, wb_i);
    step();
    npc_i = 32'hC; wb_i = 32'h1234_5633;
    push_frame(npc_i, wb_i);
    step();
    pat = 4'b1001;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      tx_ready = pat[3 - (c % 4)];
      step();
    end
    check("bp_done", exp_q.size(), 0);
    tx_ready = 1'b1;
    step();
    step();

    // Overflow
    tx_ready = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      npc_i = 32'h100 + k * 4;
      wb_i  = 32'hB0 + k;
      if (k <= 5) push_frame(npc_i, wb_i);
      step();
      if (k == 5) begin
        check("ovf_full", full, 1);
        check("ovf_count4", count, 4);
      end
    end
    check("ovf_cnt", ovf_cnt, 2);
    check("ovf_count_hold", count, 4);

    // Full with simultaneous pop: new retire on the last-byte acceptance edge
    tx_ready = 1'b1;
    repeat (8) step();
    npc_i = 32'h200; wb_i = 32'h0BAD_F00D;
    push_frame(npc_i, wb_i);
    step();
    check("fp_count", count, 4);
    check("fp_full", full, 1);
    check("fp_ovf", ovf_cnt, 2);
    drain("fp_drain", 200);
    check("fp_empty", empty, 1);

    // Reset mid-frame
    tx_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      npc_i = 32'h300 + k * 4;
      wb_i  = 32'hC0 + k;
      push_frame(npc_i, wb_i);
      step();
    end
    check("rm_count", count, 2);
    tx_ready = 1'b1;
    repeat (3) step();
    RN = 1'b0; en_i = 1'b0;
    exp_q.delete();
    step();
    check("rm_valid", tx_valid, 0);
    check("rm_count0", count, 0);
    check("rm_ovf", ovf_cnt, 0);
    check("rm_empty", empty, 1);
    RN = 1'b1;
    step();
    en_i = 1'b1; npc_i = 32'h2000; wb_i = 32'h55;
    push_frame(npc_i, wb_i);
    step();
    check("rm_new_count", count, 1);
    step();
    check("rm_new_valid", tx_valid, 1);
    check("rm_new_sync", tx_data, SYNC);
    drain("rm_drain", 40);
    check("rm_end_valid", tx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
